// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN / ILEN   : address and instruction widths
//   INST_NOP      : canonical RV NOP (addi x0,x0,0)
//   PC_STEP       : sequential fetch increment
//   fetch_entry_t : {pc, inst} payload held in the fetch queue
//   align_pc      : forces a PC to word alignment
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i, entry_i : write one entry at the tail
//   pop_i           : remove the head entry (ignored when empty)
//   flush_i         : discard all entries (wins over push/pop)
//   head_o          : current head entry (register output)
//   empty_o         : queue holds no entries
//   count_o         : number of valid entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  localparam int unsigned AW = $clog2(DEPTH) + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic           do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-2:0]];

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointer next-state
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-2:0]] <= entry_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers responses and hands {pc, inst} to decode.
// A redirect flushes buffered and in-flight instructions and restarts fetch.
// Build option: FETCH_BYPASS_EN -- when the queue is empty and nothing is
// being dropped, a memory response is presented to decode in the same cycle.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/ready/addr         : fetch request channel
//   imem_resp_valid/data              : in-order response, always accepted
//   redirect_valid/pc                 : flush and restart at redirect_pc
//   inst_valid/ready, inst_pc, inst   : decode handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [ILEN-1:0]  imem_resp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst_pc,
  output logic [ILEN-1:0]  inst
);

  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;
  // Stale responses can pile up over back-to-back redirects.
  localparam int unsigned DROP_W = 8;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              req_fire, resp_live, resp_keep, bypass;
  logic              q_push, q_pop, q_empty;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head, resp_entry;

  // Credit: never more live requests than queue slots (pop not credited).
  assign imem_req_valid = !rst && !redirect_valid &&
                          ((SUM_W'(inflight_q) + SUM_W'(q_count)) < SUM_W'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A live response belongs to a non-dropped request; it is kept unless a
  // redirect discards it this cycle.
  assign resp_live  = imem_resp_valid && (drop_q == '0);
  assign resp_keep  = resp_live && !redirect_valid;
  // Responses return in order from a sequential stream, so the PC of the
  // next kept response is tracked by one register.
  assign resp_entry = '{pc: resp_pc_q, inst: imem_resp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass     = resp_keep && q_empty;
  assign inst_valid = bypass ? 1'b1 : !q_empty;
  assign inst_pc    = bypass ? resp_entry.pc   : q_head.pc;
  assign inst       = bypass ? resp_entry.inst : q_head.inst;
`else
  assign bypass     = 1'b0;
  assign inst_valid = !q_empty;
  assign inst_pc    = q_head.pc;
  assign inst       = q_head.inst;
`endif

  assign q_push = resp_keep && !(bypass && inst_ready);
  assign q_pop  = !q_empty && inst_ready;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .entry_i (resp_entry),
    .pop_i   (q_pop),
    .flush_i (redirect_valid),
    .head_o  (q_head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // PC, in-flight and drop bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      inflight_d = '0;
      // Everything still outstanding becomes stale, less any response
      // arriving (and discarded) right now.
      drop_d     = drop_q + DROP_W'(inflight_q) - DROP_W'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
      if (resp_keep) resp_pc_d  = resp_pc_q + PC_STEP;
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_live);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Memory is either an automatic
// zero-latency model (responds with the request address as data in the
// cycle the request is accepted) or driven by hand from the test tasks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam int unsigned QD  = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst;

  logic        auto_mem, man_ready, man_resp_valid;
  logic [31:0] man_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_req_ready  = man_ready;
  assign imem_resp_valid = auto_mem ? (imem_req_valid && imem_req_ready) : man_resp_valid;
  assign imem_resp_data  = auto_mem ? imem_req_addr[31:0] : man_resp_data;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst            (inst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and leave the bench settled in the first active cycle.
  task automatic start_run();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    man_resp_valid = 1'b0;
    man_resp_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    man_resp_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    n_checks++;
    if (imem_req_addr !== RPC) begin
      n_fail++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RPC);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    n_checks++;
    if (inst_pc !== 64'h0) begin
      n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc);
    end
    n_checks++;
    if (inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst: got %h want 0", inst);
    end
  endtask

  task automatic test_stream();
    logic [63:0] exp;
    auto_mem = 1'b1; man_ready = 1'b1; inst_ready = 1'b1;
    start_run();
    for (int k = 0; k < 8; k++) begin
      exp = RPC + 64'(4 * k);
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp) begin
        n_fail++;
        $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h", k + 1, imem_req_valid, imem_req_addr, exp);
      end
      n_checks++;
      if (k >= LAT) begin
        exp = RPC + 64'(4 * (k - LAT));
        if (inst_valid !== 1'b1 || inst_pc !== exp || inst !== exp[31:0]) begin
          n_fail++;
          $display("FAIL stream_inst c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k + 1, inst_valid, inst_pc, inst, exp, exp[31:0]);
        end
      end else if (inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL stream_first_latency: got inst_valid=%b want 0", inst_valid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    logic [63:0] exp;
    auto_mem = 1'b1; man_ready = 1'b1; inst_ready = 1'b0;
    start_run();
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      tick();
    end
    n_checks++;
    if (nreq != QD) begin
      n_fail++; $display("FAIL stall_req_count: got %0d want %0d", nreq, QD);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid);
    end
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      n_fail++; $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=%h", inst_valid, inst_pc, RPC);
    end
    inst_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp = RPC + 64'(4 * k);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp || inst !== exp[31:0]) begin
        n_fail++;
        $display("FAIL stall_resume %0d: got v=%b pc=%h i=%h want v=1 pc=%h", k, inst_valid, inst_pc, inst, exp);
      end
      tick();
    end
  endtask

  task automatic test_req_stall();
    auto_mem = 1'b0; man_ready = 1'b0; inst_ready = 1'b1;
    start_run();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
        n_fail++; $display("FAIL req_hold c%0d: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, RPC);
      end
      tick();
    end
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4) begin
      n_fail++; $display("FAIL req_advance: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RPC + 64'd4);
    end
  endtask

  task automatic test_redirect();
    auto_mem = 1'b0; man_ready = 1'b1; inst_ready = 1'b1;
    start_run();
    tick();
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_credit_full: got req_valid=%b want 0", imem_req_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h1003;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_no_issue: got req_valid=%b want 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
      n_fail++; $display("FAIL redir_new_addr: got v=%b a=%h want v=1 a=1000", imem_req_valid, imem_req_addr);
    end
    man_resp_valid = 1'b1; man_resp_data = 32'hBAD0_0000;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_stale1: got inst_valid=%b want 0", inst_valid);
    end
    tick();
    man_ready = 1'b0; man_resp_data = 32'hBAD0_0004;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_stale2: got inst_valid=%b want 0", inst_valid);
    end
    tick();
    man_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_stale_gone: got inst_valid=%b want 0", inst_valid);
    end
    man_resp_valid = 1'b1; man_resp_data = 32'h0000_1000; inst_ready = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h1000) begin
      n_fail++; $display("FAIL redir_bypass: got v=%b pc=%h want v=1 pc=1000", inst_valid, inst_pc);
    end
`endif
    tick();
    man_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h1000 || inst !== 32'h0000_1000) begin
      n_fail++; $display("FAIL redir_first_inst: got v=%b pc=%h i=%h want v=1 pc=1000 i=1000", inst_valid, inst_pc, inst);
    end
  endtask

  // Continues from test_redirect: queue holds pc 0x1000, nothing in flight.
  task automatic test_redirect_collision();
    man_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1004) begin
      n_fail++; $display("FAIL coll_pre_req: got v=%b a=%h want v=1 a=1004", imem_req_valid, imem_req_addr);
    end
    tick();
    man_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    man_resp_valid = 1'b1; man_resp_data = 32'hBAD1_0000;
    inst_ready = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h1000) begin
      n_fail++; $display("FAIL coll_pop_head: got v=%b pc=%h want v=1 pc=1000", inst_valid, inst_pc);
    end
    tick();
    redirect_valid = 1'b0; redirect_pc = '0; man_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_dropped: got inst_valid=%b want 0", inst_valid);
    end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
      n_fail++; $display("FAIL coll_new_addr: got v=%b a=%h want v=1 a=2000", imem_req_valid, imem_req_addr);
    end
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0; man_resp_valid = 1'b1; man_resp_data = 32'h0000_2000; inst_ready = 1'b0;
    tick();
    man_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || inst !== 32'h0000_2000) begin
      n_fail++; $display("FAIL coll_drop_count: got v=%b pc=%h i=%h want v=1 pc=2000 i=2000", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    auto_mem = 1'b0; man_ready = 1'b0; inst_ready = 1'b0;
    start_run();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0; redirect_pc = '0; man_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top: got v=%b a=%h want v=1 a=fffffffffffffffc", imem_req_valid, imem_req_addr);
    end
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      n_fail++; $display("FAIL wrap_zero: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
    end
    man_ready = 1'b0; man_resp_valid = 1'b1; man_resp_data = INST_NOP;
    tick();
    man_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst !== INST_NOP) begin
      n_fail++; $display("FAIL wrap_inst: got v=%b pc=%h i=%h want v=1 pc=fffffffffffffffc i=%h", inst_valid, inst_pc, inst, INST_NOP);
    end
  endtask

  initial begin
    rst = 1'b1;
    auto_mem = 1'b0; man_ready = 1'b0; man_resp_valid = 1'b0; man_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_reset();
    test_backpressure();
    test_req_stall();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
